// File: rtl/pc_gen_redirect.sv
// pc_gen_redirect -- fetch-stage program-counter generator.
//
// Produces the instruction fetch address. Sequential fetches advance by INC
// when the pipeline is not stalled and memory acknowledges the current fetch.
// Supports branch redirect (with a one-entry pending-target buffer held across
// stalls/wait states), flush/exception redirect, and misaligned-fetch detection.
//
// Ports:
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   stall          in   [STALL_W] pipeline stall vector, bit 0 holds the PC
//   flush          in   exception/eret redirect strobe
//   flush_pc       in   [ADDR_W] redirect target for flush
//   branch_flag    in   branch/jump taken, from ID
//   branch_target  in   [ADDR_W] branch target
//   inst_ack       in   instruction memory returned data for current pc
//   pc             out  [ADDR_W] current fetch address
//   ce             out  instruction memory chip enable
//   fetch_err      out  misaligned-fetch exception flag
//   pend_valid     out  a branch target is buffered awaiting application
module pc_gen_redirect #(
   parameter int                ADDR_W       = 32,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
   parameter int                INC          = 4,
   parameter int                ALIGN_BITS   = 2,
   parameter int                STALL_W      = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic [ADDR_W-1:0]  flush_pc,
   input  logic               branch_flag,
   input  logic [ADDR_W-1:0]  branch_target,
   input  logic               inst_ack,
   output logic [ADDR_W-1:0]  pc,
   output logic               ce,
   output logic               fetch_err,
   output logic               pend_valid
);

   typedef enum logic [1:0] {
      S_RST = 2'd0,
      S_RUN = 2'd1,
      S_ERR = 2'd2
   } state_t;

   // Mask of low PC bits that must be zero; all-zero when the check is disabled.
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);
   localparam logic [ADDR_W-1:0] INC_W      = ADDR_W'(INC);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic                ce_q, ce_d;
   logic                fetch_err_q, fetch_err_d;
   logic                pend_valid_q, pend_valid_d;
   logic [ADDR_W-1:0]   pend_target_q, pend_target_d;

   logic                adv;
   logic                load;
   logic [ADDR_W-1:0]   load_val;

   // Only stall[0] has meaning; the remaining bits are deliberately ignored.
   logic                unused_stall;
   assign unused_stall = ^stall;

   function automatic logic misaligned(input logic [ADDR_W-1:0] addr);
      return (addr & ALIGN_MASK) != '0;
   endfunction

   assign adv = (state_q == S_RUN) && !stall[0] && inst_ack;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      ce_d          = ce_q;
      fetch_err_d   = fetch_err_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      load          = 1'b0;
      load_val      = pc_q;

      case (state_q)
         S_RST: begin
            // First fetch after reset presents RESET_VECTOR with ce raised.
            ce_d    = 1'b1;
            state_d = S_RUN;
         end

         S_RUN: begin
            if (flush) begin
               load         = 1'b1;
               load_val     = flush_pc;
               pend_valid_d = 1'b0;
            end else if (adv && pend_valid_q) begin
               // Buffered target wins over a same-cycle branch.
               load         = 1'b1;
               load_val     = pend_target_q;
               pend_valid_d = 1'b0;
            end else if (adv && branch_flag) begin
               load     = 1'b1;
               load_val = branch_target;
            end else if (adv) begin
               load     = 1'b1;
               load_val = pc_q + INC_W;
            end else if (branch_flag) begin
               // Newest branch overwrites any older pending target.
               pend_target_d = branch_target;
               pend_valid_d  = 1'b1;
            end

            if (load) begin
               pc_d = load_val;
               if (misaligned(load_val)) begin
                  fetch_err_d  = 1'b1;
                  ce_d         = 1'b0;
                  pend_valid_d = 1'b0;
                  state_d      = S_ERR;
               end
            end
         end

         S_ERR: begin
            pend_valid_d = 1'b0;
            if (flush) begin
               pc_d = flush_pc;
               if (!misaligned(flush_pc)) begin
                  fetch_err_d = 1'b0;
                  ce_d        = 1'b1;
                  state_d     = S_RUN;
               end
            end
         end

         default: begin
            state_d = S_RST;
            ce_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_RST;
         pc_q          <= RESET_VECTOR;
         ce_q          <= 1'b0;
         fetch_err_q   <= 1'b0;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         ce_q          <= ce_d;
         fetch_err_q   <= fetch_err_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
      end
   end

   assign pc         = pc_q;
   assign ce         = ce_q;
   assign fetch_err  = fetch_err_q;
   assign pend_valid = pend_valid_q;

endmodule

// File: tb/tb_pc_gen_redirect.sv
// Testbench for pc_gen_redirect: a 32-bit instance (RESET_VECTOR=BFC00000)
// and an 8-bit instance (for wrap-around) share the stimulus. The driver
// pushes the expected post-edge outputs into a queue; the monitor pops and
// compares on the following falling edge.
module tb_pc_gen_redirect;

   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] flush_pc;
   logic        branch_flag;
   logic [31:0] branch_target;
   logic        inst_ack;

   logic [31:0] pc;
   logic        ce, fetch_err, pend_valid;
   logic [7:0]  pc8;
   logic        ce8, fetch_err8, pend_valid8;

   pc_gen_redirect #(
      .ADDR_W(32), .RESET_VECTOR(32'hBFC0_0000), .INC(4), .ALIGN_BITS(2), .STALL_W(6)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
      .branch_flag(branch_flag), .branch_target(branch_target), .inst_ack(inst_ack),
      .pc(pc), .ce(ce), .fetch_err(fetch_err), .pend_valid(pend_valid)
   );

   pc_gen_redirect #(
      .ADDR_W(8), .RESET_VECTOR(8'h00), .INC(4), .ALIGN_BITS(2), .STALL_W(6)
   ) dut8 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc[7:0]),
      .branch_flag(branch_flag), .branch_target(branch_target[7:0]), .inst_ack(inst_ack),
      .pc(pc8), .ce(ce8), .fetch_err(fetch_err8), .pend_valid(pend_valid8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          step;
      logic [31:0] pc;
      logic        ce;
      logic        fe;
      logic        pv;
      logic        chk8;
      logic [7:0]  pc8;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   step_no  = 0;

   task automatic chk(input string name, input int step, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s step=%0d actual=%h required=%h", name, step, act, req);
      end
   endtask

   // Monitor: outputs are presented every cycle; compare each queued expectation.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("pc", e.step, pc, e.pc);
         chk("ce", e.step, {31'd0, ce}, {31'd0, e.ce});
         chk("fetch_err", e.step, {31'd0, fetch_err}, {31'd0, e.fe});
         chk("pend_valid", e.step, {31'd0, pend_valid}, {31'd0, e.pv});
         if (e.chk8) chk("pc8", e.step, {24'd0, pc8}, {24'd0, e.pc8});
      end
   end

   // Drive one cycle of inputs, then queue the expected post-edge outputs.
   task automatic cyc(input logic r, input logic s, input logic f, input logic [31:0] fpc,
                      input logic b, input logic [31:0] bt, input logic a,
                      input logic [31:0] epc, input logic ece, input logic efe,
                      input logic epv, input logic c8, input logic [7:0] epc8);
      exp_t e;
      rst           = r;
      stall         = {5'b10110, s};
      flush         = f;
      flush_pc      = fpc;
      branch_flag   = b;
      branch_target = bt;
      inst_ack      = a;
      @(posedge clk);
      #1;
      e.step = step_no;
      e.pc   = epc;
      e.ce   = ece;
      e.fe   = efe;
      e.pv   = epv;
      e.chk8 = c8;
      e.pc8  = epc8;
      exp_q.push_back(e);
      step_no++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; stall = '0; flush = 1'b0; flush_pc = '0;
      branch_flag = 1'b0; branch_target = '0; inst_ack = 1'b0;

      // Reset and sequential run
      cyc(1,0,0,0,     0,0,     1, 32'hBFC0_0000, 0,0,0, 0,8'h00);
      cyc(1,0,0,0,     0,0,     1, 32'hBFC0_0000, 0,0,0, 1,8'h00);
      cyc(0,0,0,0,     0,0,     1, 32'hBFC0_0000, 1,0,0, 1,8'h00);
      cyc(0,0,0,0,     0,0,     1, 32'hBFC0_0004, 1,0,0, 1,8'h04);
      cyc(0,0,0,0,     0,0,     1, 32'hBFC0_0008, 1,0,0, 1,8'h08);

      // Stall and wait states
      cyc(0,0,1,32'h100, 0,0,   1, 32'h100, 1,0,0, 1,8'h00);
      cyc(0,1,0,0,     0,0,     1, 32'h100, 1,0,0, 0,8'h00);
      cyc(0,1,0,0,     0,0,     1, 32'h100, 1,0,0, 0,8'h00);
      cyc(0,1,0,0,     0,0,     1, 32'h100, 1,0,0, 0,8'h00);
      cyc(0,0,0,0,     0,0,     0, 32'h100, 1,0,0, 0,8'h00);
      cyc(0,0,0,0,     0,0,     0, 32'h100, 1,0,0, 0,8'h00);
      cyc(0,0,0,0,     0,0,     1, 32'h104, 1,0,0, 0,8'h00);

      // Branch during stall, then overwrite of a pending target
      cyc(0,0,1,32'h200, 0,0,   1, 32'h200, 1,0,0, 0,8'h00);
      cyc(0,1,0,0,     1,32'h400, 1, 32'h200, 1,0,1, 0,8'h00);
      cyc(0,1,0,0,     0,0,     1, 32'h200, 1,0,1, 0,8'h00);
      cyc(0,0,0,0,     0,0,     1, 32'h400, 1,0,0, 0,8'h00);
      cyc(0,1,0,0,     1,32'h300, 1, 32'h400, 1,0,1, 0,8'h00);
      cyc(0,1,0,0,     1,32'h500, 1, 32'h400, 1,0,1, 0,8'h00);
      // Same-cycle branch is ignored when a pending target is applied
      cyc(0,0,0,0,     1,32'h600, 1, 32'h500, 1,0,0, 0,8'h00);

      // Flush priority over stall, branch and pending entry
      cyc(0,1,0,0,     1,32'h700, 1, 32'h500, 1,0,1, 0,8'h00);
      cyc(0,1,1,32'h180, 1,32'h300, 1, 32'h180, 1,0,0, 0,8'h00);

      // Misalignment
      cyc(0,0,0,0,     1,32'h202, 1, 32'h202, 0,1,0, 0,8'h00);
      cyc(0,0,0,0,     1,32'h400, 1, 32'h202, 0,1,0, 0,8'h00);
      cyc(0,1,0,0,     1,32'h400, 1, 32'h202, 0,1,0, 0,8'h00);
      cyc(0,0,1,32'h181, 0,0,   1, 32'h181, 0,1,0, 0,8'h00);
      cyc(0,0,1,32'h180, 0,0,   1, 32'h180, 1,0,0, 1,8'h80);
      cyc(0,0,0,0,     0,0,     1, 32'h184, 1,0,0, 1,8'h84);

      // Sequential advance across a misaligned-free boundary, then 8-bit wrap
      cyc(0,0,1,32'h1FC, 0,0,   0, 32'h1FC, 1,0,0, 1,8'hFC);
      cyc(0,0,0,0,     0,0,     1, 32'h200, 1,0,0, 1,8'h00);
      cyc(0,0,0,0,     0,0,     1, 32'h204, 1,0,0, 1,8'h04);

      // Reset mid-operation with a pending branch
      cyc(0,1,0,0,     1,32'h300, 1, 32'h204, 1,0,1, 0,8'h00);
      cyc(1,1,0,0,     1,32'h300, 1, 32'hBFC0_0000, 0,0,0, 1,8'h00);
      cyc(0,0,0,0,     0,0,     1, 32'hBFC0_0000, 1,0,0, 1,8'h00);
      cyc(0,0,0,0,     0,0,     1, 32'hBFC0_0004, 1,0,0, 1,8'h04);

      inst_ack = 1'b0;
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_gen_redirect.md
Name: pc_gen_redirect

Overview:
Parametrised program-counter generator for the fetch stage, successor to the fixed 32-bit increment-only PC register. It adds a configurable reset vector, branch redirect with a pending-target buffer held across stalls, flush/exception redirect, and a fetch handshake with wait-state memory. It also detects misaligned fetches and feeds the IF/ID stage and instruction ROM/cache.

Parameters:
ADDR_W, 32, PC width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; first address fetched after reset
INC, 4, byte increment per sequential fetch
ALIGN_BITS, 2, low PC bits that must be zero; 0 disables the alignment check
STALL_W, 6, width of the pipeline stall vector; only bit 0 is used

Ports:
clk  in  1  clock
rst  in  1  reset
stall  in  STALL_W  pipeline stall vector; stall[0]=1 holds the PC
flush  in  1  exception/eret redirect strobe
flush_pc  in  ADDR_W  redirect target when flush=1
branch_flag  in  1  branch/jump taken, from ID
branch_target  in  ADDR_W  target when branch_flag=1
inst_ack  in  1  instruction memory has returned data for the current pc
pc  out  ADDR_W  current fetch address
ce  out  1  instruction memory chip enable
fetch_err  out  1  misaligned-fetch exception flag
pend_valid  out  1  a branch target is buffered, waiting to be applied

Behaviour:
- Reset is synchronous and active-high (rst), on clock clk.
- Reset values: pc=RESET_VECTOR, ce=0, fetch_err=0, pend_valid=0, pend_target=0, state=S_RST. Reset overrides all other inputs, including mid-handshake.
- States:
  - S_RST: ce=0. On the first non-reset edge: ce<=1, pc is unchanged, go to S_RUN.
  - The first fetch presented with ce=1 is therefore RESET_VECTOR.
- Advance condition: adv = (state==S_RUN) && !stall[0] && inst_ack.
- Next-PC priority, evaluated each edge in S_RUN:
  1. flush=1: pc<=flush_pc; pend_valid<=0. Applies regardless of stall, inst_ack or branch_flag.
  2. adv && pend_valid: pc<=pend_target; pend_valid<=0. A simultaneous branch_flag is ignored.
  3. adv && branch_flag: pc<=branch_target.
  4. adv: pc<=pc+INC, truncated to ADDR_W bits (wraps silently at 2^ADDR_W).
  5. !adv && branch_flag: pend_target<=branch_target; pend_valid<=1; pc holds. If an entry is already pending, the newer target overwrites it.
  6. Otherwise pc holds.
- Alignment check (ALIGN_BITS>0): if the value about to be loaded into pc has nonzero low ALIGN_BITS bits:
  - pc loads that value anyway;
  - fetch_err<=1, ce<=0, state<=S_ERR on the same edge.
- S_ERR:
  - pc holds; branch_flag and inst_ack are ignored; pend_valid is cleared.
  - Only flush exits. It applies the same alignment check to flush_pc; if flush_pc is aligned: pc<=flush_pc, fetch_err<=0, ce<=1, state<=S_RUN.
  - A misaligned flush_pc stays in S_ERR with pc<=flush_pc.
- RESET_VECTOR is not alignment-checked. It is a designer responsibility.
- Latency: a redirect becomes visible on pc one edge after the accepting edge. There is no combinational path from any input to pc or ce.
- stall[STALL_W-1:1] is unused and has no effect.
- Invariants:
  - ce=0 exactly in S_RST and S_ERR.
  - pend_valid=1 only in S_RUN.

Test Plan:
- Reset and sequential run: rst=1 for 2 cycles, then release, inst_ack=1, RESET_VECTOR=32'hBFC0_0000 -> ce=0 in reset; the cycle after release shows pc=BFC00000 with ce=1, followed by BFC00004 and BFC00008.
- Stall and wait states: pc=0x100; assert stall[0] for 3 cycles, then inst_ack=0 for 2 cycles -> pc stays 0x100 throughout, then 0x104 on the first edge with stall[0]=0 and inst_ack=1.
- Branch during stall: pc=0x200, stall[0]=1, one-cycle branch_flag with target 0x400 -> pend_valid=1 and pc stays 0x200; after stall releases pc=0x400 and pend_valid=0. A second branch to 0x500 while pending -> pc ends at 0x500.
- Flush priority: same cycle flush=1 (flush_pc=0x180), branch_flag=1 (0x300), stall[0]=1, pend_valid=1 -> next pc=0x180, pend_valid=0.
- Misalignment: branch to 0x202 -> pc=0x202, fetch_err=1, ce=0. Further branches and acks are ignored; flush to 0x180 -> fetch_err=0, ce=1, pc=0x180.
- Wrap and reset mid-operation: ADDR_W=8, pc=8'hFC -> next pc=8'h00. Asserting rst during a pending branch -> pc=RESET_VECTOR, pend_valid=0, ce=0.
